// File: rtl/irq_ctrl_n.sv
// Masked fixed-priority interrupt controller: latches one winning channel, holds irq_o until ack, pulses irq_ret_o on mret.
// Optional `IRQ_EDGE_TRIG_EN: rising-edge pending registers instead of level-sensitive requests.
module irq_ctrl_n #(
   parameter int N_IRQ      = 16,
   parameter int CAUSE_BASE = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IRQ-1:0] irq_req_i,
   input  logic [N_IRQ-1:0] irq_mask_i,
   input  logic             mie_i,
   input  logic             irq_ack_i,
   input  logic             mret_i,
   output logic             irq_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ret_o,
   output logic             busy_o
);

   localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam logic [N_IRQ-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE, RET} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cur_q, cur_d;
   logic [N_IRQ-1:0] cand;
   logic [CW-1:0]    win;
   logic             win_vld;
   logic             ack_acc;
   logic [30:0]      code;

   assign ack_acc = (state_q == REQ) && mie_i && irq_ack_i;

`ifdef IRQ_EDGE_TRIG_EN
   logic [N_IRQ-1:0] pend_q, pend_d, prev_q, clr;

   // A fresh edge in the ack cycle re-arms the channel being serviced.
   always_comb begin
      clr    = ack_acc ? (ONE << cur_q) : '0;
      pend_d = (pend_q & ~clr) | (irq_req_i & ~prev_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= '0;
         prev_q <= '0;
      end else begin
         pend_q <= pend_d;
         prev_q <= irq_req_i;
      end
   end

   assign cand = pend_q & irq_mask_i;
`else
   assign cand = irq_req_i & irq_mask_i;
`endif

   // Descending scan so the lowest set index is the final assignment.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win     = CW'(i);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      unique case (state_q)
         IDLE: begin
            if (mie_i && win_vld) begin
               cur_d   = win;
               state_d = REQ;
            end
         end
         REQ:     if (ack_acc) state_d = SERVICE;
         SERVICE: if (mret_i)  state_d = RET;
         RET:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
      end
   end

   assign code        = 31'(CAUSE_BASE) + 31'(cur_q);
   assign irq_o       = (state_q == REQ) && mie_i;
   assign irq_cause_o = (state_q != IDLE) ? {1'b1, code} : 32'd0;
   assign irq_ret_o   = (state_q == RET) ? (ONE << cur_q) : '0;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Testbench for irq_ctrl_n: directed walk through the main scenarios plus randomized traffic against a reference model.
module tb_irq_ctrl_n;

   localparam int N  = 16;
   localparam int CB = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [N-1:0]  irq_req_i;
   logic [N-1:0]  irq_mask_i;
   logic          mie_i;
   logic          irq_ack_i;
   logic          mret_i;
   logic          irq_o;
   logic [31:0]   irq_cause_o;
   logic [N-1:0]  irq_ret_o;
   logic          busy_o;

   int n_checks = 0;
   int n_errors = 0;

   irq_ctrl_n #(.N_IRQ(N), .CAUSE_BASE(CB)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .irq_req_i(irq_req_i), .irq_mask_i(irq_mask_i),
      .mie_i(mie_i), .irq_ack_i(irq_ack_i), .mret_i(mret_i), .irq_o(irq_o),
      .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase 0=waiting, 1=requesting, 2=in handler, 3=returning.
   int           m_phase = 0;
   int           m_cur   = 0;
   logic [N-1:0] m_pend  = '0;
   logic [N-1:0] m_prev  = '0;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_edge();
      logic [N-1:0] c;
      logic [N-1:0] rise;
      if (rst_i) begin
         m_phase = 0; m_cur = 0; m_pend = '0; m_prev = '0;
         return;
      end
      rise = irq_req_i & ~m_prev;
`ifdef IRQ_EDGE_TRIG_EN
      c = m_pend & irq_mask_i;
`else
      c = irq_req_i & irq_mask_i;
`endif
      case (m_phase)
         0: if (mie_i && c != 0) begin m_cur = lowest(c); m_phase = 1; end
         1: if (mie_i && irq_ack_i) begin m_phase = 2; m_pend[m_cur] = 1'b0; end
         2: if (mret_i) m_phase = 3;
         default: m_phase = 0;
      endcase
      m_pend = m_pend | rise;
      m_prev = irq_req_i;
   endtask

   task automatic model_compare();
      logic [31:0] e_cause;
      logic [N-1:0] e_ret;
      e_cause = (m_phase != 0) ? (32'h8000_0000 | 32'(CB + m_cur)) : 32'd0;
      e_ret   = (m_phase == 3) ? N'(1 << m_cur) : '0;
      check("m_irq",   32'(irq_o),       32'((m_phase == 1) && mie_i));
      check("m_cause", irq_cause_o,      e_cause);
      check("m_ret",   32'(irq_ret_o),   32'(e_ret));
      check("m_busy",  32'(busy_o),      32'(m_phase != 0));
   endtask

   task automatic tick();
      @(negedge clk_i);
      model_compare();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic pulse_ack();
      irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
   endtask

   task automatic pulse_mret();
      mret_i = 1'b1; tick(); mret_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; irq_req_i = 16'hFFFF; irq_mask_i = 16'hFFFF;
      mie_i = 1'b1; irq_ack_i = 1'b0; mret_i = 1'b0;
      @(posedge clk_i); model_edge(); #1;
      tick();
      check("rst_irq",   32'(irq_o), 0);
      check("rst_cause", irq_cause_o, 0);
      check("rst_ret",   32'(irq_ret_o), 0);
      check("rst_busy",  32'(busy_o), 0);
      rst_i = 1'b0;

`ifndef IRQ_EDGE_TRIG_EN
      tick();
      check("first_irq",   32'(irq_o), 1);
      check("first_cause", irq_cause_o, 32'h8000_0010);
      check("first_busy",  32'(busy_o), 1);
      pulse_ack(); pulse_mret();
      check("ret0", 32'(irq_ret_o), 32'h0001);
      irq_req_i = 16'h0028;
      tick(); tick();
      check("prio_cause", irq_cause_o, 32'h8000_0013);
      pulse_ack(); pulse_mret();
      check("ret3", 32'(irq_ret_o), 32'h0008);
      tick();
      check("ret3_one_cycle", 32'(irq_ret_o), 0);
      check("idle_gap_irq",   32'(irq_o), 0);
      irq_req_i = 16'h0020;
      tick();
      check("next_irq",   32'(irq_o), 1);
      check("next_cause", irq_cause_o, 32'h8000_0015);
      mie_i = 1'b0; #1;
      check("gate_irq",   32'(irq_o), 0);
      check("gate_cause", irq_cause_o, 32'h8000_0015);
      irq_req_i = 16'h0021;
      tick();
      check("nopreempt_cause", irq_cause_o, 32'h8000_0015);
      mie_i = 1'b1; #1;
      check("regate_irq", 32'(irq_o), 1);
      pulse_mret();
      check("mret_req_busy", 32'(busy_o), 1);
      check("mret_req_ret",  32'(irq_ret_o), 0);
      mie_i = 1'b0; pulse_ack(); mie_i = 1'b1; #1;
      check("ack_masked_irq", 32'(irq_o), 1);
      pulse_ack();
      check("svc_irq", 32'(irq_o), 0);
      pulse_mret();
      check("ret5", 32'(irq_ret_o), 32'h0020);
      irq_req_i = '0;
      tick();
      pulse_mret();
      check("mret_idle_ret",  32'(irq_ret_o), 0);
      check("mret_idle_busy", 32'(busy_o), 0);
      irq_req_i = 16'h0004; irq_mask_i = 16'hFFFB;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("masked_irq", 32'(irq_o), 0);
      end
      irq_mask_i = 16'hFFFF;
      tick();
      check("unmask_irq",   32'(irq_o), 1);
      check("unmask_cause", irq_cause_o, 32'h8000_0012);
      pulse_ack();
      irq_req_i = '0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_busy",  32'(busy_o), 0);
      check("midrst_cause", irq_cause_o, 0);
      pulse_mret();
      check("midrst_ret", 32'(irq_ret_o), 0);
`else
      irq_req_i = '0;
      tick(); tick();
      irq_req_i = 16'h0080;
      tick();
      irq_req_i = '0;
      tick();
      check("edge_irq",   32'(irq_o), 1);
      check("edge_cause", irq_cause_o, 32'h8000_0017);
      pulse_ack(); pulse_mret();
      check("edge_ret", 32'(irq_ret_o), 32'h0080);
      tick();
`endif

      for (int i = 0; i < 3000; i++) begin
         rst_i      = ($urandom_range(0, 99) == 0);
         irq_req_i  = 16'($urandom) & 16'($urandom) & 16'($urandom);
         irq_mask_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
         mie_i      = ($urandom_range(0, 7) != 0);
         irq_ack_i  = ($urandom_range(0, 3) == 0);
         mret_i     = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst_i = 1'b0; irq_ack_i = 1'b0; mret_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
